// File: rtl/qoi_index_stage.sv
// QOI_OP_INDEX stage: hashes each pixel into a colour table, reports hit/miss
// with the ready-made op byte and writes the pixel back, behind a 2-stage pipe.
module qoi_index_stage #(
    parameter int unsigned COMPONENTS  = 4,
    parameter int unsigned INDEX_BITS  = 6,
    parameter int unsigned STRICT_INIT = 1,
    parameter int unsigned HIT_CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [8*COMPONENTS-1:0] pixel,
    input  logic                    pixel_valid,
    output logic                    pixel_ready,
    output logic [8*COMPONENTS-1:0] out_pixel,
    output logic [INDEX_BITS-1:0]   out_index,
    output logic [7:0]              out_op,
    output logic                    out_hit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [HIT_CNT_W-1:0]    hit_count
);
    localparam int unsigned PW    = 8 * COMPONENTS;
    localparam int unsigned DEPTH = 1 << INDEX_BITS;

    // RGB-only pixels hash as if alpha were opaque.
    function automatic logic [INDEX_BITS-1:0] qoi_hash(input logic [PW-1:0] p);
        logic [12:0] r, g, b, a, sum;
        r   = 13'(p[PW-1 -: 8]);
        g   = 13'(p[PW-9 -: 8]);
        b   = 13'(p[PW-17 -: 8]);
        a   = (COMPONENTS == 4) ? 13'(p[7:0]) : 13'd255;
        sum = r * 13'd3 + g * 13'd5 + b * 13'd7 + a * 13'd11;
        return sum[INDEX_BITS-1:0];
    endfunction

    logic [PW-1:0]         table_q [DEPTH];
    logic [PW-1:0]         table_d [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;

    logic                  a_valid_q, a_valid_d;
    logic [PW-1:0]         a_pixel_q, a_pixel_d;
    logic [INDEX_BITS-1:0] a_hash_q, a_hash_d;

    logic                  out_valid_q, out_valid_d;
    logic [PW-1:0]         out_pixel_q, out_pixel_d;
    logic [INDEX_BITS-1:0] out_index_q, out_index_d;
    logic                  out_hit_q, out_hit_d;
    logic [HIT_CNT_W-1:0]  hit_count_q, hit_count_d;

    logic                  advance;
    logic                  lookup_hit;

    always_comb begin
        advance     = !out_valid_q | out_ready;
        pixel_ready = advance & !flush;

        // Table is read and written by the same stage, so a repeat of the
        // pixel just ahead sees the freshly written entry.
        lookup_hit  = (table_q[a_hash_q] == a_pixel_q) &
                      ((STRICT_INIT != 0) | valid_q[a_hash_q]);

        table_d     = table_q;
        valid_d     = valid_q;
        a_valid_d   = a_valid_q;
        a_pixel_d   = a_pixel_q;
        a_hash_d    = a_hash_q;
        out_valid_d = out_valid_q;
        out_pixel_d = out_pixel_q;
        out_index_d = out_index_q;
        out_hit_d   = out_hit_q;
        hit_count_d = hit_count_q;

        if (flush) begin
            table_d     = '{default: '0};
            valid_d     = '0;
            a_valid_d   = 1'b0;
            out_valid_d = 1'b0;
            hit_count_d = '0;
        end else if (advance) begin
            a_valid_d   = pixel_valid;
            a_pixel_d   = pixel;
            a_hash_d    = qoi_hash(pixel);
            out_valid_d = a_valid_q;
            if (a_valid_q) begin
                out_pixel_d        = a_pixel_q;
                out_index_d        = a_hash_q;
                out_hit_d          = lookup_hit;
                table_d[a_hash_q]  = a_pixel_q;
                valid_d[a_hash_q]  = 1'b1;
                if (lookup_hit && (hit_count_q != '1))
                    hit_count_d = hit_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            table_q     <= '{default: '0};
            valid_q     <= '0;
            a_valid_q   <= 1'b0;
            a_pixel_q   <= '0;
            a_hash_q    <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_index_q <= '0;
            out_hit_q   <= 1'b0;
            hit_count_q <= '0;
        end else begin
            table_q     <= table_d;
            valid_q     <= valid_d;
            a_valid_q   <= a_valid_d;
            a_pixel_q   <= a_pixel_d;
            a_hash_q    <= a_hash_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_index_q <= out_index_d;
            out_hit_q   <= out_hit_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign out_pixel = out_pixel_q;
    assign out_index = out_index_q;
    assign out_op    = 8'(out_index_q);
    assign out_hit   = out_hit_q;
    assign out_valid = out_valid_q;
    assign hit_count = hit_count_q;

endmodule

// File: tb/tb_qoi_index_stage.sv
// Bench for qoi_index_stage: strict and non-strict instances share stimulus and
// are scored against a table model evaluated in pixel-acceptance order.
module tb_qoi_index_stage;
    typedef struct {
        logic [31:0] pix;
        int          idx;
        int          op;
        bit          hit;
        int          cnt;
        int          cyc;
    } res_t;

    logic        clk = 1'b0;
    logic        rst, flush, pixel_valid, out_ready;
    logic [31:0] pixel;

    logic        s_ready, s_hit, s_valid, n_ready, n_hit, n_valid;
    logic [31:0] s_pix, n_pix;
    logic [5:0]  s_idx, n_idx;
    logic [7:0]  s_op, n_op;
    logic [15:0] s_cnt, n_cnt;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int acc_n   = 0;
    bit lat_chk = 0;

    res_t exq_s[$], exq_n[$], log_s[$], log_n[$];
    logic [31:0] mtbl [2][64];
    bit          mwr  [2][64];
    int          mcnt [2];

    bit          prev_stall = 0;
    logic [63:0] prev_out;

    qoi_index_stage #(.COMPONENTS(4), .INDEX_BITS(6), .STRICT_INIT(1), .HIT_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .pixel(pixel), .pixel_valid(pixel_valid),
        .pixel_ready(s_ready), .out_pixel(s_pix), .out_index(s_idx), .out_op(s_op),
        .out_hit(s_hit), .out_valid(s_valid), .out_ready(out_ready), .hit_count(s_cnt));

    qoi_index_stage #(.COMPONENTS(4), .INDEX_BITS(6), .STRICT_INIT(0), .HIT_CNT_W(16)) dut_ns (
        .clk(clk), .rst(rst), .flush(flush), .pixel(pixel), .pixel_valid(pixel_valid),
        .pixel_ready(n_ready), .out_pixel(n_pix), .out_index(n_idx), .out_op(n_op),
        .out_hit(n_hit), .out_valid(n_valid), .out_ready(out_ready), .hit_count(n_cnt));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 64; i++) begin
                mtbl[s][i] = '0;
                mwr[s][i]  = 0;
            end
            mcnt[s] = 0;
        end
        exq_s.delete();
        exq_n.delete();
    endtask

    task automatic model_accept(input logic [31:0] p);
        int   h;
        res_t e;
        h = (int'(p[31:24]) * 3 + int'(p[23:16]) * 5 + int'(p[15:8]) * 7 + int'(p[7:0]) * 11) % 64;
        for (int s = 0; s < 2; s++) begin
            e.pix = p;
            e.idx = h;
            e.op  = h;
            e.cyc = cyc;
            e.hit = (mtbl[s][h] == p) && (s == 1 || mwr[s][h]);
            mtbl[s][h] = p;
            mwr[s][h]  = 1;
            if (e.hit && mcnt[s] < 65535) mcnt[s]++;
            e.cnt = mcnt[s];
            if (s == 1) exq_s.push_back(e);
            else        exq_n.push_back(e);
        end
    endtask

    task automatic score(input int s, input logic [31:0] pix, input logic [5:0] idx,
                         input logic [7:0] op, input logic hit, input logic [15:0] cnt);
        res_t e, g;
        g.pix = pix; g.idx = int'(idx); g.op = int'(op); g.hit = hit; g.cnt = int'(cnt); g.cyc = cyc;
        if (s == 1) begin
            if (exq_s.size() == 0) begin chk("spurious1", 1, 0); return; end
            e = exq_s.pop_front();
            log_s.push_back(g);
        end else begin
            if (exq_n.size() == 0) begin chk("spurious0", 1, 0); return; end
            e = exq_n.pop_front();
            log_n.push_back(g);
        end
        chk($sformatf("pix%0d", s), pix, e.pix);
        chk($sformatf("idx%0d", s), idx, e.idx);
        chk($sformatf("hit%0d", s), hit, e.hit);
        chk($sformatf("cnt%0d", s), cnt, e.cnt);
        if (e.hit) chk($sformatf("op%0d", s), op, e.op);
        if (lat_chk && s == 1) chk("latency", cyc - e.cyc, 2);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            model_clear();
            prev_stall = 0;
            chk("rst_valid", s_valid, 0);
            chk("rst_valid_ns", n_valid, 0);
            chk("rst_cnt", s_cnt, 0);
            chk("rst_outs", {s_pix, s_idx, s_op, s_hit}, 0);
        end else if (flush) begin
            chk("flush_ready", s_ready, 0);
            model_clear();
            prev_stall = 0;
        end else begin
            chk("ready", s_ready, !s_valid | out_ready);
            chk("ready_ns", n_ready, !n_valid | out_ready);
            if (prev_stall) chk("stall_stable", {s_valid, s_pix, s_idx, s_hit, s_cnt}, prev_out);
            if (s_valid && out_ready) score(1, s_pix, s_idx, s_op, s_hit, s_cnt);
            if (n_valid && out_ready) score(0, n_pix, n_idx, n_op, n_hit, n_cnt);
            if (pixel_valid && s_ready) begin
                model_accept(pixel);
                acc_n++;
            end
            prev_stall = s_valid & !out_ready;
            prev_out   = {7'd0, s_valid, s_pix, s_idx, s_hit, s_cnt};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] p);
        bit ok;
        ok = 0;
        pixel = p;
        pixel_valid = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = s_ready;
            tick();
        end
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_results(input int n);
        for (int i = 0; i < 60; i++) begin
            if (log_s.size() >= n && log_n.size() >= n) break;
            tick();
        end
        if (log_s.size() < n || log_n.size() < n) chk("result_timeout", log_s.size(), n);
    endtask

    task automatic clr_logs();
        log_s.delete();
        log_n.delete();
    endtask

    task automatic do_flush();
        flush = 1;
        tick();
        flush = 0;
    endtask

    logic [31:0] pal [6] = '{32'h00000000, 32'h000000FF, 32'h400000FF,
                             32'hAABBCCDD, 32'h80808080, 32'h000000FE};
    logic [31:0] pv  [4] = '{32'hAABBCCDD, 32'h01020304, 32'hAABBCCDD, 32'h11111111};

    initial begin
        int base;
        rst = 1; flush = 0; pixel = '0; pixel_valid = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // back-to-back identical pixel: miss then hit, 2-cycle latency
        clr_logs();
        lat_chk = 1;
        send(32'h000000FF);
        send(32'h000000FF);
        pixel_valid = 0;
        wait_results(2);
        lat_chk = 0;
        chk("t1_hit0", log_s[0].hit, 0);
        chk("t1_hit1", log_s[1].hit, 1);
        chk("t1_idx", log_s[1].idx, 53);
        chk("t1_op", log_s[1].op, 8'h35);
        chk("t1_cnt", log_s[1].cnt, 1);

        // flush with a result parked at the output
        out_ready = 0;
        send(32'h12345678);
        pixel_valid = 0;
        tick(); tick();
        chk("t5_pre_valid", s_valid, 1);
        do_flush();
        chk("t5_valid", s_valid, 0);
        chk("t5_valid_ns", n_valid, 0);
        chk("t5_cnt", s_cnt, 0);
        out_ready = 1;
        clr_logs();
        send(32'h000000FF);
        pixel_valid = 0;
        wait_results(1);
        chk("t5_miss", log_s[0].hit, 0);

        // zero pixel against a fresh table
        do_flush();
        clr_logs();
        send(32'h00000000);
        pixel_valid = 0;
        wait_results(1);
        chk("t2_strict_hit", log_s[0].hit, 1);
        chk("t2_strict_op", log_s[0].op, 0);
        chk("t2_ns_miss", log_n[0].hit, 0);

        // collisions on index 53: latest writer wins
        do_flush();
        clr_logs();
        send(32'h000000FF);
        send(32'h400000FF);
        send(32'h000000FF);
        pixel_valid = 0;
        wait_results(3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t3_hit%0d", k), log_s[k].hit, 0);
            chk($sformatf("t3_idx%0d", k), log_s[k].idx, 53);
        end

        // backpressure: two in flight, nothing lost
        do_flush();
        clr_logs();
        out_ready = 0;
        base = acc_n;
        pixel_valid = 1;
        for (int i = 0; i < 5; i++) begin
            if (acc_n - base < 4) pixel = pv[acc_n - base];
            tick();
        end
        chk("t4_accepted", acc_n - base, 2);
        chk("t4_ready_low", s_ready, 0);
        out_ready = 1;
        for (int i = 0; i < 40 && (acc_n - base) < 4; i++) begin
            pixel = pv[acc_n - base];
            tick();
        end
        pixel_valid = 0;
        wait_results(4);
        for (int k = 0; k < 4; k++) chk($sformatf("t4_order%0d", k), log_s[k].pix, pv[k]);

        // async reset while a result is presented
        do_flush();
        clr_logs();
        send(32'h000000FF);
        pixel_valid = 0;
        wait_results(1);
        out_ready = 0;
        send(32'h55667788);
        pixel_valid = 0;
        tick(); tick();
        chk("t6_pre_valid", s_valid, 1);
        #1 rst = 1;
        #1;
        chk("t6_async_valid", s_valid, 0);
        chk("t6_async_valid_ns", n_valid, 0);
        chk("t6_async_cnt", s_cnt, 0);
        tick();
        rst = 0;
        out_ready = 1;
        clr_logs();
        send(32'h000000FF);
        pixel_valid = 0;
        wait_results(1);
        chk("t6_miss", log_s[0].hit, 0);

        // random traffic with occasional flushes
        for (int i = 0; i < 1500; i++) begin
            pixel_valid = ($urandom_range(3) != 0);
            pixel       = ($urandom_range(3) == 0) ? $urandom : pal[$urandom_range(5)];
            out_ready   = ($urandom_range(2) != 0);
            flush       = ($urandom_range(99) == 0);
            tick();
        end
        flush = 0;
        pixel_valid = 0;
        out_ready = 1;
        repeat (5) tick();
        chk("drain_s", exq_s.size(), 0);
        chk("drain_n", exq_n.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
